// File: rtl/memory_responder.sv
// Single-port synchronous memory responder for imem/dmem requests with configurable wait states.
// Optional misalignment checking is enabled with `define MEMORY_RESPONDER_MISALIGN_CHECK_EN.
module memory_responder #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic        req_fcn,
   input  logic [2:0]  req_typ,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   localparam logic       M_XWR = 1'b1;

   localparam logic [2:0] MT_X  = 3'd0;
   localparam logic [2:0] MT_B  = 3'd1;
   localparam logic [2:0] MT_H  = 3'd2;
   localparam logic [2:0] MT_W  = 3'd3;
   localparam logic [2:0] MT_BU = 3'd5;
   localparam logic [2:0] MT_HU = 3'd6;
   localparam logic [2:0] MT_WU = 3'd7;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          res_valid_q, res_valid_d;
   logic [1:0]    sz_q, sz_d;
   logic          sgn_q, sgn_d;
   logic [1:0]    off_q, off_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q;
   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic [1:0]    req_sz;
   logic          req_sgn;
   logic          misalign;
   logic          req_err;
   logic [1:0]    eff_off;
   logic [3:0]    byte_en;
   logic [31:0]   wdata;
   logic          wr_en;
   logic [AW-1:0] idx;
   logic [31:0]   shifted;
   logic [31:0]   lane_data;

   logic unused_addr;
   assign unused_addr = ^req_addr[31:AW+2];

   assign accept = (state_q == IDLE) && req_valid && !reset;
   assign idx    = req_addr[AW+1:2];

   // Unknown and MT_X type codes fall through to a full-word access.
   always_comb begin
      req_sz  = SZ_WORD;
      req_sgn = 1'b0;
      case (req_typ)
         MT_B:               begin req_sz = SZ_BYTE; req_sgn = 1'b1; end
         MT_BU:              req_sz = SZ_BYTE;
         MT_H:               begin req_sz = SZ_HALF; req_sgn = 1'b1; end
         MT_HU:              req_sz = SZ_HALF;
         MT_W, MT_WU, MT_X:  req_sz = SZ_WORD;
         default:            req_sz = SZ_WORD;
      endcase
   end

   assign misalign = ((req_sz == SZ_HALF) && req_addr[0]) ||
                     ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef MEMORY_RESPONDER_MISALIGN_CHECK_EN
   assign req_err = misalign;
   assign eff_off = req_addr[1:0];
`else
   assign req_err = 1'b0;
   always_comb begin
      eff_off = req_addr[1:0];
      if (req_sz == SZ_HALF) begin
         eff_off = {req_addr[1], 1'b0};
      end else if (req_sz == SZ_WORD) begin
         eff_off = 2'b00;
      end
   end
   logic unused_misalign;
   assign unused_misalign = misalign;
`endif

   always_comb begin
      byte_en = 4'b1111;
      wdata   = req_data;
      case (req_sz)
         SZ_BYTE: begin
            byte_en = 4'b0001 << eff_off;
            wdata   = {4{req_data[7:0]}};
         end
         SZ_HALF: begin
            byte_en = 4'b0011 << eff_off;
            wdata   = {2{req_data[15:0]}};
         end
         default: begin
            byte_en = 4'b1111;
            wdata   = req_data;
         end
      endcase
   end

   assign wr_en = accept && (req_fcn == M_XWR) && !req_err;

   // Array is never reset; contents survive a reset by design.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en && byte_en[b]) begin
            mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (accept) begin
         rdata_q <= mem_q[idx];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sz_d        = sz_q;
      sgn_d       = sgn_q;
      off_d       = off_q;
      wr_d        = wr_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sz_d  = req_sz;
               sgn_d = req_sgn;
               off_d = eff_off;
               wr_d  = (req_fcn == M_XWR);
               err_d = req_err;
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      res_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         res_valid_q <= 1'b0;
         sz_q        <= SZ_WORD;
         sgn_q       <= 1'b0;
         off_q       <= 2'b00;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         sz_q        <= sz_d;
         sgn_q       <= sgn_d;
         off_q       <= off_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
      end
   end

   // Lane extraction works only from registered fields, so req_* never reaches res_*.
   assign shifted = rdata_q >> {off_q, 3'b000};

   always_comb begin
      lane_data = rdata_q;
      case (sz_q)
         SZ_BYTE: lane_data = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
         SZ_HALF: lane_data = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
         default: lane_data = rdata_q;
      endcase
   end

   assign res_valid = res_valid_q;
   assign res_data  = (res_valid_q && !wr_q && !err_q) ? lane_data : 32'd0;
   assign res_err   = res_valid_q && err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: directed cases plus randomized accesses vs a byte model.
module tb_memory_responder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WS    = 2;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_fcn;
   logic [2:0]  req_typ;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_mem [DEPTH];

   memory_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_fcn   (req_fcn),
      .req_typ   (req_typ),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_err   (res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Reference: byte-level memory, access size in bytes, offsets in plain arithmetic.
   task automatic model_access(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] exp_data,
                               output logic exp_err);
      int n;
      int off;
      int idx;
      bit sgn;
      logic [31:0] val;
      logic [31:0] mask;
      n   = (typ == 3'd1 || typ == 3'd5) ? 1 : (typ == 3'd2 || typ == 3'd6) ? 2 : 4;
      sgn = (typ == 3'd1 || typ == 3'd2);
      off = int'(addr % 4);
      idx = int'((addr / 4) % DEPTH);
      exp_err  = 1'b0;
      exp_data = 32'd0;
`ifdef MEMORY_RESPONDER_MISALIGN_CHECK_EN
      if (off % n != 0) begin
         exp_err = 1'b1;
         return;
      end
`else
      off = off - (off % n);
`endif
      if (fcn) begin
         for (int i = 0; i < n; i++) begin
            model_mem[idx][8*(off+i) +: 8] = data[8*i +: 8];
         end
      end else begin
         val = model_mem[idx] >> (8 * off);
         if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            val  = val & mask;
            if (sgn && val[8*n-1]) val = val | ~mask;
         end
         exp_data = val;
      end
   endtask

   task automatic do_req(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] got,
                         output logic got_err);
      logic [31:0] exp_data;
      logic        exp_err;
      int          k;
      bit          seen;
      model_access(fcn, typ, addr, data, exp_data, exp_err);
      req_fcn   = fcn;
      req_typ   = typ;
      req_addr  = addr;
      req_data  = data;
      req_valid = 1'b1;
      k    = 0;
      seen = 0;
      while (!seen && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (res_valid) seen = 1;
      end
      check("latency", 32'(k), 32'(WS + 1));
      got     = res_data;
      got_err = res_err;
      check("res_data", got, exp_data);
      check("res_err", {31'd0, got_err}, {31'd0, exp_err});
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pulse_once", {31'd0, res_valid}, 32'd0);
      check("idle_data", res_data, 32'd0);
   endtask

   logic [31:0] d;
   logic        e;
   logic [2:0]  typ_tab [8];
   int          vcount;

   initial begin
      typ_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      req_data  = 32'd0;
      req_fcn   = 1'b0;
      req_typ   = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_data", res_data, 32'd0);
      check("rst_err", {31'd0, res_err}, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < int'(DEPTH); i++) begin
         do_req(1'b1, 3'd3, 32'(i * 4), $urandom, d, e);
      end

      do_req(1'b1, 3'd3, 32'h10, 32'h8765_4321, d, e);
      check("sw_data0", d, 32'd0);
      do_req(1'b0, 3'd3, 32'h10, 32'd0, d, e);
      check("lw10", d, 32'h8765_4321);
      do_req(1'b0, 3'd1, 32'h13, 32'd0, d, e);
      check("lb13", d, 32'hFFFF_FF87);
      do_req(1'b0, 3'd5, 32'h13, 32'd0, d, e);
      check("lbu13", d, 32'h0000_0087);
      do_req(1'b0, 3'd2, 32'h12, 32'd0, d, e);
      check("lh12", d, 32'hFFFF_8765);
      do_req(1'b0, 3'd6, 32'h10, 32'd0, d, e);
      check("lhu10", d, 32'h0000_4321);
      do_req(1'b1, 3'd1, 32'h11, 32'h0000_00AA, d, e);
      do_req(1'b0, 3'd3, 32'h10, 32'd0, d, e);
      check("sb_merge", d, 32'h8765_AA21);
      do_req(1'b1, 3'd2, 32'h12, 32'h0000_BEEF, d, e);
      do_req(1'b0, 3'd3, 32'h10, 32'd0, d, e);
      check("sh_merge", d, 32'hBEEF_AA21);

      do_req(1'b0, 3'd3, 32'h11, 32'd0, d, e);
`ifdef MEMORY_RESPONDER_MISALIGN_CHECK_EN
      check("mis_lw_err", {31'd0, e}, 32'd1);
      check("mis_lw_data", d, 32'd0);
      do_req(1'b1, 3'd3, 32'h11, 32'h1234_5678, d, e);
      do_req(1'b0, 3'd3, 32'h10, 32'd0, d, e);
      check("mis_sw_kept", d, 32'hBEEF_AA21);
`else
      check("mis_lw_err", {31'd0, e}, 32'd0);
      check("mis_lw_data", d, 32'hBEEF_AA21);
`endif

      do_req(1'b1, 3'd3, 32'h40, 32'h0000_0055, d, e);
      do_req(1'b0, 3'd3, 32'h00, 32'd0, d, e);
      check("alias", d, 32'h0000_0055);

      // Reset during WAIT of a read: no response, contents intact.
      req_fcn   = 1'b0;
      req_typ   = 3'd3;
      req_addr  = 32'h10;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (res_valid) vcount++;
      end
      check("rst_abandon", 32'(vcount), 32'd0);
      do_req(1'b0, 3'd3, 32'h00, 32'd0, d, e);
      check("rst_intact", d, 32'h0000_0055);

      for (int i = 0; i < 80; i++) begin
         do_req(1'($urandom_range(0, 1)), typ_tab[$urandom_range(0, 7)],
                32'($urandom_range(0, 127)), $urandom, d, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Single-port synchronous memory that serves the core's instruction or data memory requests: accepts one request on the MemoryIn fields, performs a masked byte/half/word read or write, and returns a one-cycle `res_valid` pulse with load data after a configurable number of wait states. It sits on the memory side of the core's `imem`/`dmem` ports and is the agent whose `res_valid` drives the core's cache-miss stall.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two, ≥ 2.
- `WAIT_STATES`, 0: extra cycles between acceptance and response; 0..15.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present; must be held stable, with all `req_*` fields, until the cycle in which `res_valid` is 1.
- `req_addr` in 32: byte address.
- `req_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_fcn` in Bundle::MemoryWriteSignal: `M_XWR` = write; `M_XRD` or `M_X` = read.
- `req_typ` in Bundle::MemoryMaskType: `MT_B`, `MT_H`, `MT_W`, `MT_BU`, `MT_HU`, `MT_WU`; `MT_X` or any other code is treated as `MT_W`.
- `res_valid` out 1: response pulse, high for exactly one cycle per accepted request.
- `res_data` out 32: load data, valid when `res_valid` is 1; 0 for writes.
- `res_err` out 1: misaligned access, valid when `res_valid` is 1.

## Operation
- State machine: `IDLE`, `WAIT`, `RESP`.
- `IDLE`: if `req_valid` is 1, the request is accepted. Go to `WAIT` with the counter loaded to `WAIT_STATES-1` if `WAIT_STATES>0`, else go to `RESP`.
- `WAIT`: decrement the counter. Go to `RESP` when the counter is 0.
- `RESP`: `res_valid`=1. Always return to `IDLE`. The request visible in this cycle is the old, held one and is not accepted.
- Word index is `req_addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses alias and wrap modulo `DEPTH_WORDS*4`.
- Lane select:
  - `B`/`BU`: byte lane `addr[1:0]`.
  - `H`/`HU`: half lane `addr[1]`.
  - `W`/`WU`: full word.
- Write:
  - Write data is shifted into the selected lane.
  - Only the enabled bytes change.
  - The array is updated on the acceptance edge (IDLE→next).
- Read:
  - The word is latched into a read-data register on the acceptance edge.
  - The selected lane is extracted.
  - `B` and `H` sign-extend; `BU` and `HU` zero-extend; `W`/`WU` pass through.
- `res_data` is 0 when `res_valid` is 0 and for write responses.
- If `req_valid` drops during `WAIT`, the response is still issued and the array write (if any) has already committed.
- Reset:
  - Values: state `IDLE`, counter 0, `res_valid`=0, `res_data`=0, `res_err`=0.
  - Reset mid-transaction abandons the response. A write that was already accepted stays committed.
  - Array contents are not cleared.

## Timing
- Request accepted in cycle N (IDLE with `req_valid`=1) → `res_valid` in cycle N+1+`WAIT_STATES`.
- Next acceptance no earlier than cycle N+2+`WAIT_STATES`. Peak throughput is one access per `WAIT_STATES+2` cycles.
- All outputs are registered; there is no combinational path from `req_*` to `res_*`.
- A write followed by a read of the same address returns the new data. No bypass is needed because accesses are serialized.

## Configuration
- Macro: `MEMORY_RESPONDER_MISALIGN_CHECK_EN`.
- Defined:
  - A misaligned access raises `res_err`=1 in the response cycle. Misaligned means `H`/`HU` with `addr[0]`=1, or `W`/`WU` with `addr[1:0]`≠0.
  - A misaligned write is suppressed (array unchanged).
  - A misaligned read returns `res_data`=0.
- Undefined:
  - Misaligned low address bits are forced to alignment: `addr[0]` cleared for halves, `addr[1:0]` cleared for words.
  - The access proceeds normally.
  - `res_err` is tied 0.

## Test plan
- `WAIT_STATES`=2: SW 0x8765_4321 to 0x10 at cycle 0 → `res_valid` only in cycle 3, `res_data`=0. Then LW 0x10 → 0x8765_4321.
- After that word: LB 0x13 → 0xFFFF_FF87; LBU 0x13 → 0x0000_0087; LH 0x12 → 0xFFFF_8765; LHU 0x10 → 0x0000_4321.
- SB 0xAA to 0x11 over 0x8765_4321 → LW 0x10 returns 0x8765_AA21. SH 0xBEEF to 0x12 → 0xBEEF_AA21.
- Misaligned LW 0x11:
  - With the macro: `res_err`=1 and `res_data`=0. SW 0x11 leaves the word unchanged.
  - Without the macro: behaves as LW 0x10, `res_err`=0.
- `DEPTH_WORDS`=16: SW 0x55 to 0x40 → LW 0x00 returns 0x55 (aliasing).
- Assert `reset` in the `WAIT` cycle of a read → no `res_valid` follows. The next request is accepted normally and earlier array contents are intact.
